instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Consumes the instruction address produced by the program-counter register and reads the instruction word from instruction memory over a request/grant/response port. It buffers returned words and delivers them, tagged with their address, to decode over a valid/ready handshake. Supports multiple outstanding reads, in-order return, flush on redirect, and misalignment faults. It sits between the PC stage and the decode stage of the MIPS core.

## Interface
- DEPTH, 2: combined limit on outstanding memory reads plus buffered instructions; must be ≥1.
- CLK  in  1  clock; all state updates on the rising edge. The PC register changes on the falling edge, so `addr` is stable at the rising edge.
- RST  in  1  asynchronous, active-high reset.
- addr_valid  in  1  the PC stage offers a fetch address.
- addr  in  32  byte address of the instruction.
- addr_ready  out  1  the address is accepted this cycle when `addr_valid && addr_ready`.
- flush  in  1  redirect: discard all buffered and in-flight instructions.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  read address; equals `addr`.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data is valid. Responses return in request order, at the earliest 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  the buffer head is valid.
- instr  out  32  instruction word.
- instr_pc  out  32  address of `instr`.
- instr_fault  out  1  the head is a misaligned-fetch fault entry.
- instr_ready  in  1  decode consumes the head.

## Operation
- Counters:
  - `outst`: reads granted but not yet returned.
  - `occ`: buffer occupancy.
  - `drop`: responses still to be discarded after a flush.
- credit = `(outst + occ < DEPTH) || pop`, where pop = `instr_valid && instr_ready`.
- Aligned address (`addr[1:0] == 0`):
  - imem_req = `addr_valid && credit && !flush && drop == 0`.
  - addr_ready = `imem_req && imem_gnt`.
  - On accept, `addr` is pushed into the pending-PC queue and `outst` increments.
- Misaligned address:
  - No memory request is issued.
  - addr_ready = `addr_valid && credit && !flush && outst == 0 && drop == 0`.
  - On accept, the entry `{fault=1, pc=addr, instr=0}` is pushed into the buffer.
- Response handling:
  - When `imem_rvalid && drop > 0`: discard the response and decrement `drop`.
  - Otherwise `imem_rvalid` pops the pending-PC queue and pushes `{0, pc, imem_rdata}` into the buffer; `outst` decrements.
- Outputs `instr`, `instr_pc` and `instr_fault` are registered buffer-head values and are held while `instr_valid && !instr_ready`.
- Flush cycle:
  - Buffer and pending-PC queue are cleared.
  - `drop` += `outst` − (`imem_rvalid` ? 1 : 0); a response arriving in the flush cycle is itself discarded.
  - `outst` is set to 0, and `addr_ready` and `imem_req` are 0.
  - `instr_valid` is 0 from the next cycle.
- Simultaneous push and pop on a full buffer is legal and keeps occupancy unchanged.
- `imem_rvalid` with `outst == 0 && drop == 0` is a protocol error: ignored, and an assertion fires.
- Reset sets:
  - all counters and queues empty;
  - `instr_valid`, `instr_fault`, `instr` and `instr_pc` to 0;
  - `imem_req` and `addr_ready` to 0 while RST is high.
- Reset mid-operation abandons in-flight reads. The memory must also be reset.

## Timing
- Accept at cycle N → earliest `imem_rvalid` at N+1 → `instr_valid` at N+2. There is no bypass from `imem_rdata` to `instr`.
- With 1-cycle memory, DEPTH=2, and `instr_ready` held high, one instruction is accepted per cycle, thanks to the same-cycle pop credit.
- A misaligned accept at N → `instr_valid` with fault at N+1.
- flush at N → first accept possible at N+1 if `drop` is 0, otherwise once `drop` reaches 0.
- `imem_req` must not depend on `imem_gnt`. Inputs `addr_valid`, `addr`, `imem_gnt` and `instr_ready` are sampled at the rising edge only.

## Structure
- Package `fetch_pkg`:
  - DEPTH default;
  - entry width constant (65 bits: fault, pc, instr);
  - field offset constants;
  - counter width `$clog2(DEPTH+1)`.
- Sub-module `fetch_fifo` (parameterised width and depth, synchronous clear, async reset), instantiated twice:
  - pending-PC queue, 32-bit wide;
  - instruction buffer, 65-bit wide.

## Test plan
- Reset → `instr_valid=0`, `imem_req=0`. Stream 0x00, 0x04, 0x08 with 1-cycle memory and grant always high → instructions out in order at N+2, one per cycle, `instr_pc` matching.
- Memory 3-cycle latency, DEPTH=2 → at most 2 outstanding; third address stalls with `addr_ready=0` until the first response is consumed.
- `instr_ready` low for 5 cycles with the buffer full → outputs held stable, no new `imem_req`. Release → drain in order.
- Two reads outstanding, flush at N with `imem_rvalid=1` → that response and the next are discarded, and the following address 0x100 returns normally as the first `instr`.
- Address 0x102 with `outst=0` → `instr_fault=1`, `instr_pc=0x102`, `instr=0` at N+1, no memory request issued.
- Assert RST asynchronously mid-stream → all outputs 0 immediately, counters cleared, normal fetch resumes after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared constants and entry helpers for the instruction fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int FETCH_DEPTH = 2;

  // Buffer entry layout: {fault, pc, instr}
  localparam int ENTRY_W   = 65;
  localparam int INSTR_LSB = 0;
  localparam int PC_LSB    = 32;
  localparam int FAULT_BIT = 64;

  localparam int CNT_W = $clog2(FETCH_DEPTH + 1);

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t make_entry(input logic        fault,
                                        input logic [31:0] pc,
                                        input logic [31:0] word);
    return {fault, pc, word};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : register-array FIFO with synchronous clear and async reset
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : PC-to-decode fetch with outstanding reads, flush and faults
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_valid,
  input  logic [31:0] addr,
  output logic        addr_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]  outst;
  logic [CW-1:0]  occ;
  logic [CW-1:0]  drop;
  logic [CW-1:0]  drop_nxt;
  logic [CW:0]    in_use;

  logic           pop;
  logic           credit;
  logic           aligned;
  logic           base_ok;
  logic           accept_al;
  logic           accept_mis;
  logic           rsp_take;
  logic           rsp_drop;

  logic [31:0]    pend_head;
  logic           pend_empty;
  entry_t         buf_head;
  entry_t         buf_wdata;
  logic           buf_empty;
  logic           buf_push;

  assign in_use  = {1'b0, outst} + {1'b0, occ};
  assign pop     = instr_valid && instr_ready;
  assign credit  = (in_use < (CW+1)'(DEPTH)) || pop;
  assign aligned = (addr[1:0] == 2'b00);

  // Shared gating for both aligned and misaligned accepts
  assign base_ok = !rst && addr_valid && credit && !flush && (drop == '0);

  assign imem_req   = base_ok && aligned;
  assign imem_addr  = addr;
  assign accept_al  = imem_req && imem_gnt;
  // Misaligned entries wait for in-flight reads so the stream stays in order
  assign accept_mis = base_ok && !aligned && (outst == '0);
  assign addr_ready = accept_al || accept_mis;

  assign rsp_drop = imem_rvalid && (drop != '0);
  assign rsp_take = imem_rvalid && (drop == '0) && !pend_empty && !flush;

  assign buf_push  = accept_mis || rsp_take;
  assign buf_wdata = accept_mis ? make_entry(1'b1, addr, 32'h0)
                                : make_entry(1'b0, pend_head, imem_rdata);

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pend (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (accept_al),
    .push_data (addr),
    .pop       (rsp_take),
    .head      (pend_head),
    .empty     (pend_empty),
    .count     (outst)
  );

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (buf_push),
    .push_data (buf_wdata),
    .pop       (pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .count     (occ)
  );

  assign instr_valid = !buf_empty;
  assign instr       = instr_valid ? buf_head[INSTR_LSB +: 32] : 32'h0;
  assign instr_pc    = instr_valid ? buf_head[PC_LSB +: 32]    : 32'h0;
  assign instr_fault = instr_valid && buf_head[FAULT_BIT];

  // A response landing in the flush cycle is one of the abandoned reads
  always_comb begin
    drop_nxt = drop;
    if (flush) begin
      drop_nxt = drop + outst;
      if (imem_rvalid && (drop_nxt != '0)) drop_nxt = drop_nxt - CW'(1);
    end else if (rsp_drop) begin
      drop_nxt = drop - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop <= '0;
    else     drop <= drop_nxt;
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outst == '0) && (drop == '0)));

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : directed bench with a queue-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_valid, addr_ready, flush;
  logic [31:0] addr, imem_addr, imem_rdata, instr, instr_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic        instr_valid, instr_fault, instr_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr_valid  (addr_valid),
    .addr        (addr),
    .addr_ready  (addr_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault),
    .instr_ready (instr_ready)
  );

  typedef struct packed {logic fault; logic [31:0] pc; logic [31:0] ins;} ent_t;
  typedef struct packed {logic [31:0] a; int due;} mreq_t;

  // Reference model: what decode should see, what is in flight, what to drop
  ent_t        mbuf[$];
  logic [31:0] mpend[$];
  int          mdrop = 0;
  // Memory model: granted reads in order with their due cycle
  mreq_t       mq[$];

  int          lat = 1;
  int          cyc = 0;
  int          max_out = 0;
  logic        av = 1'b0, fl = 1'b0, rdy = 1'b1;
  logic [31:0] a = 32'h0;
  bit          last_acc;

  int          n_chk = 0, n_pass = 0;
  int          acc_cyc[$];
  int          pop_cyc[$];
  ent_t        pop_ent[$];

  function automatic logic [31:0] mem_word(input logic [31:0] x);
    return x ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); pop_cyc.delete(); pop_ent.delete(); max_out = 0;
  endtask

  // One clock: drive at negedge, compare just before posedge, advance model after it
  task automatic cycle();
    bit          rv, e_valid, pop, credit, alig, e_req, e_ardy, d_req;
    ent_t        hd;
    logic [31:0] rd, d_addr;
    addr_valid  = av;
    addr        = a;
    flush       = fl;
    instr_ready = rdy;
    imem_gnt    = 1'b1;
    rv          = (mq.size() > 0) && (mq[0].due <= cyc);
    rd          = rv ? mem_word(mq[0].a) : 32'h0;
    imem_rvalid = rv;
    imem_rdata  = rd;
    #4;
    e_valid = (mbuf.size() > 0);
    hd      = e_valid ? mbuf[0] : '0;
    pop     = e_valid && rdy;
    credit  = ((mpend.size() + mbuf.size()) < D) || pop;
    alig    = (a[1:0] == 2'b00);
    e_req   = av && alig && credit && !fl && (mdrop == 0);
    e_ardy  = alig ? e_req : (av && credit && !fl && (mpend.size() == 0) && (mdrop == 0));
    chk("instr_valid", instr_valid, e_valid);
    chk("imem_req", imem_req, e_req);
    chk("addr_ready", addr_ready, e_ardy);
    if (e_valid) begin
      chk("instr_pc", instr_pc, hd.pc);
      chk("instr", instr, hd.ins);
      chk("instr_fault", instr_fault, hd.fault);
    end
    if (e_req) chk("imem_addr", imem_addr, a);
    d_req  = imem_req;
    d_addr = imem_addr;
    if (instr_valid && rdy) begin
      pop_cyc.push_back(cyc);
      pop_ent.push_back({instr_fault, instr_pc, instr});
    end
    last_acc = av && addr_ready;
    if (last_acc) acc_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    if (fl) begin
      mdrop += mpend.size() - (rv ? 1 : 0);
      mpend.delete();
      mbuf.delete();
    end else begin
      if (pop) void'(mbuf.pop_front());
      if (rv) begin
        if (mdrop > 0) mdrop--;
        else if (mpend.size() > 0) mbuf.push_back({1'b0, mpend.pop_front(), rd});
      end
      if (e_ardy) begin
        if (alig) mpend.push_back(a);
        else      mbuf.push_back({1'b1, a, 32'h0});
      end
    end
    if (rv) void'(mq.pop_front());
    if (d_req && imem_gnt) mq.push_back('{a: d_addr, due: cyc + lat});
    if (mq.size() > max_out) max_out = mq.size();
    cyc++;
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] x, input logic r);
    int k = 0;
    av = 1'b1; a = x; rdy = r; fl = 1'b0;
    do begin
      cycle();
      k++;
    end while (!last_acc && k < 40);
    if (!last_acc) begin
      n_chk++;
      $display("FAIL accept_timeout: addr %0h not accepted, required within 40 cycles", x);
    end
    av = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    av = 1'b0; fl = 1'b0; rdy = 1'b1;
    while ((mbuf.size() > 0 || mpend.size() > 0 || mq.size() > 0 || mdrop > 0) && k < 40) begin
      cycle();
      k++;
    end
    cycle();
    if (k >= 40) begin
      n_chk++;
      $display("FAIL drain_timeout: pipeline still busy after 40 cycles, required empty");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000ns, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fcyc;
    rst = 1'b1; addr_valid = 1'b1; addr = 32'h0; flush = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b1;
    #3;
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_addr_ready", addr_ready, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_fault", instr_fault, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream with 1-cycle memory
    lat = 1; clear_logs();
    offer(32'h0, 1'b1); offer(32'h4, 1'b1); offer(32'h8, 1'b1);
    drain();
    chk("t1_pops", pop_ent.size(), 3);
    if (pop_ent.size() >= 3 && acc_cyc.size() >= 3) begin
      chk("t1_acc_rate", acc_cyc[2] - acc_cyc[0], 2);
      chk("t1_lat0", pop_cyc[0] - acc_cyc[0], 2);
      chk("t1_lat2", pop_cyc[2] - acc_cyc[2], 2);
      chk("t1_pc0", pop_ent[0].pc, 32'h0);
      chk("t1_pc1", pop_ent[1].pc, 32'h4);
      chk("t1_pc2", pop_ent[2].pc, 32'h8);
      chk("t1_ins0", pop_ent[0].ins, 32'hDEAD0000);
      chk("t1_ins2", pop_ent[2].ins, 32'hDEAD0008);
    end

    // 3-cycle memory: third address waits for credit
    lat = 3; clear_logs();
    offer(32'h20, 1'b1); offer(32'h24, 1'b1); offer(32'h28, 1'b1);
    drain();
    chk("t2_max_outst", max_out, 2);
    if (acc_cyc.size() >= 3) begin
      chk("t2_gap1", acc_cyc[1] - acc_cyc[0], 1);
      chk("t2_gap2", acc_cyc[2] - acc_cyc[0], 4);
    end

    // Decode stalled with a full buffer
    lat = 1; clear_logs();
    offer(32'h40, 1'b0); offer(32'h44, 1'b0);
    av = 1'b1; a = 32'h48; rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_hold_req", imem_req, 1'b0);
      chk("t3_hold_valid", instr_valid, 1'b1);
      chk("t3_hold_pc", instr_pc, 32'h40);
      chk("t3_hold_ins", instr, 32'hDEAD0040);
    end
    offer(32'h48, 1'b1);
    drain();
    chk("t3_pops", pop_ent.size(), 3);
    if (pop_ent.size() >= 3) begin
      chk("t3_pc0", pop_ent[0].pc, 32'h40);
      chk("t3_pc1", pop_ent[1].pc, 32'h44);
      chk("t3_pc2", pop_ent[2].pc, 32'h48);
    end

    // Flush with two reads in flight and a response in the flush cycle
    lat = 2; clear_logs();
    offer(32'h60, 1'b1); offer(32'h64, 1'b1);
    fcyc = cyc;
    av = 1'b1; a = 32'h100; fl = 1'b1; rdy = 1'b1;
    cycle();
    chk("t4_flush_req", imem_req, 1'b0);
    fl = 1'b0;
    offer(32'h100, 1'b1);
    drain();
    chk("t4_pops", pop_ent.size(), 1);
    if (pop_ent.size() >= 1) begin
      chk("t4_pc", pop_ent[0].pc, 32'h100);
      chk("t4_ins", pop_ent[0].ins, 32'hDEAD0100);
    end
    if (acc_cyc.size() >= 3) chk("t4_reaccept", acc_cyc[2] - fcyc, 2);

    // Misaligned fetches
    lat = 1; clear_logs();
    offer(32'h102, 1'b0);
    chk("t5_valid", instr_valid, 1'b1);
    chk("t5_fault", instr_fault, 1'b1);
    chk("t5_pc", instr_pc, 32'h102);
    chk("t5_ins", instr, 32'h0);
    chk("t5_no_mem", mq.size(), 0);
    offer(32'h84, 1'b1); offer(32'h106, 1'b1);
    drain();
    if (acc_cyc.size() >= 3) chk("t5_mis_wait", acc_cyc[2] - acc_cyc[1], 2);
    chk("t5_pops", pop_ent.size(), 3);
    if (pop_ent.size() >= 3) begin
      chk("t5_pop1_pc", pop_ent[1].pc, 32'h84);
      chk("t5_pop2_fault", pop_ent[2].fault, 1'b1);
      chk("t5_pop2_pc", pop_ent[2].pc, 32'h106);
    end

    // Asynchronous reset in the middle of a stream
    lat = 1; clear_logs();
    offer(32'h200, 1'b1); offer(32'h204, 1'b1);
    addr_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", instr_valid, 1'b0);
    chk("t6_req", imem_req, 1'b0);
    chk("t6_ardy", addr_ready, 1'b0);
    chk("t6_instr", instr, 32'h0);
    chk("t6_pc", instr_pc, 32'h0);
    chk("t6_fault", instr_fault, 1'b0);
    imem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mbuf.delete(); mpend.delete(); mq.delete(); mdrop = 0;
    rst = 1'b0;
    clear_logs();
    offer(32'h300, 1'b1); offer(32'h304, 1'b1);
    drain();
    chk("t6_pops", pop_ent.size(), 2);
    if (pop_ent.size() >= 2) begin
      chk("t6_pc0", pop_ent[0].pc, 32'h300);
      chk("t6_pc1", pop_ent[1].pc, 32'h304);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
